display_mode: RTL and testbench
===============================

DISPLAY_MODE -- requirements
Module: display_mode

Interface
REQ-001 Parameter ELEMENT_WIDTH, default `ELEMENT_WIDTH, element bit width; SHALL be at most 8.
REQ-002 Parameter ADDR_WIDTH, default `BRAM_ADDR_WIDTH, memory address width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 mode_active  in  1  block enabled while high.
REQ-006 rx_data  in  8  received UART byte.
REQ-007 rx_done  in  1  rx_data holds a new byte.
REQ-008 clear_rx_buffer  out  1  one-cycle pulse that consumes the current rx byte.
REQ-009 tx_data  out  8  byte to transmit.
REQ-010 tx_start  out  1  one-cycle transmit strobe.
REQ-011 tx_busy  in  1  UART transmitter busy; rises the cycle after tx_start.
REQ-012 query_req  out  1  slot-info request, held high until query_ack.
REQ-013 query_slot  out  4  slot being queried.
REQ-014 query_ack  in  1  manager response valid.
REQ-015 slot_valid  in  1  queried slot holds a committed matrix; sampled with query_ack.
REQ-016 info_m, info_n  in  5 each  committed dimensions (1..16); sampled with query_ack.
REQ-017 info_addr  in  ADDR_WIDTH  committed base address; sampled with query_ack.
REQ-018 mem_rd_en  out  1  one-cycle read strobe.
REQ-019 mem_rd_addr  out  ADDR_WIDTH  read address.
REQ-020 mem_rd_data  in  ELEMENT_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-021 timeout_reset  in  1  abort request from the top-level timer.
REQ-022 sub_state  out  4  current FSM state code.
REQ-023 error_code  out  4  `ERR_NONE or `ERR_DIM_RANGE.

Function
REQ-024 States and codes: IDLE=0, WAIT_SLOT=1, QUERY=2, RD_ISSUE=3, RD_WAIT=4, CONVERT=5, SEND_D2=6, SEND_D1=7, SEND_D0=8, SEND_SPACE=9, SEND_NEWLINE=10, DONE=11. Unused codes go to IDLE.
REQ-025 tx_start, clear_rx_buffer and mem_rd_en default to 0 each cycle and SHALL be pulses.
REQ-026 IDLE -> WAIT_SLOT unconditionally. Clears the row counter, column counter and element counter.
REQ-027 WAIT_SLOT, rx_done with '0'-'9', 'A'-'F' or 'a'-'f':
- query_slot = the hex value.
- Pulse clear_rx_buffer.
- error_code = `ERR_NONE.
- Go to QUERY.
REQ-028 WAIT_SLOT, rx_done with CR, LF or space: pulse clear_rx_buffer and stay.
REQ-029 WAIT_SLOT, rx_done with any other byte:
- Pulse clear_rx_buffer.
- error_code = `ERR_DIM_RANGE.
- Send '!' only if tx_busy is low.
- Stay.
REQ-030 QUERY holds query_req high until query_ack.
- On query_ack with slot_valid=1: latch m, n and addr, then go to RD_ISSUE.
- On query_ack with slot_valid=0: error_code = `ERR_DIM_RANGE, send '!' (when !tx_busy), return to WAIT_SLOT.
REQ-031 RD_ISSUE: mem_rd_en=1, mem_rd_addr = base + element counter (ADDR_WIDTH wrap), then RD_WAIT.
REQ-032 RD_WAIT: capture mem_rd_data into the element register, then CONVERT.
REQ-033 CONVERT: split the element (0..255) into hundreds, tens and ones in one cycle, then SEND_D2.
REQ-034 Digit sends suppress leading zeros; value 0 sends the single byte "0".
- SEND_D2 is skipped when hundreds=0.
- SEND_D1 is skipped when hundreds=0 and tens=0.
REQ-035 Every transmit state emits its byte only in a cycle where tx_busy=0, then advances; otherwise it holds with tx_start=0.
REQ-036 After SEND_D0:
- Column != n-1: go to SEND_SPACE, which sends 0x20.
- Column == n-1: go to SEND_NEWLINE, which sends 0x0A. No trailing space.
REQ-037 SEND_SPACE and SEND_NEWLINE increment the element counter.
- SEND_SPACE increments the column.
- SEND_NEWLINE clears the column and increments the row.
- Next state is DONE when the element counter was m*n-1, else RD_ISSUE.
REQ-038 DONE -> IDLE.
REQ-039 Counters SHALL be wide enough for m*n up to 256 without overflow; use a 9-bit element counter.
REQ-040 timeout_reset in WAIT_SLOT or QUERY -> IDLE, with query_req=0.
REQ-041 timeout_reset in any other state is ignored.
REQ-042 mode_active low, any state:
- sub_state=IDLE.
- query_req, mem_rd_en, tx_start and clear_rx_buffer = 0.
- The next activation starts fresh.

Reset
REQ-043 On rst_n low, asynchronously:
- sub_state=IDLE, error_code=`ERR_NONE.
- tx_data, mem_rd_addr and query_slot = 0.
- All strobes, query_req and counters = 0.
- Reset mid-transmission abandons the matrix without a further tx_start.

Verification
REQ-044 Stimulus: byte '3'; slot 3 = 2x3 at addr 0x10 holding 1,2,3,10,0,255. Required:
- query_slot=3.
- Reads of 0x10..0x15 in order.
- TX bytes exactly "1 2 3\n10 0 255\n".
- Then sub_state returns to IDLE.
REQ-045 Stimulus: byte 'x'. Required: one "!", error_code=`ERR_DIM_RANGE, sub_state stays 1, no query_req.
REQ-046 Stimulus: byte 'F' with slot_valid=0 at query_ack. Required: one "!", `ERR_DIM_RANGE, back to WAIT_SLOT, no mem_rd_en.
REQ-047 Stimulus: 16x16 matrix with tx_busy held high 20 cycles after every tx_start. Required:
- 256 reads.
- No byte lost or duplicated.
- Last byte 0x0A.
REQ-048 Stimulus: rst_n low during SEND_D1, then mode_active dropped during RD_WAIT in a second run. Required: all outputs at their reset values or idle immediately, sub_state=0, no further TX.

Source files
------------

// File: rtl/display_mode_if.sv
// Bus bundle for display_mode: UART byte path, slot-info query channel and
// element read port. display_mode uses the master side; the environment the slave side.
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 8
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif
`ifndef ERR_NONE
`define ERR_NONE 4'h0
`endif
`ifndef ERR_DIM_RANGE
`define ERR_DIM_RANGE 4'h2
`endif

interface display_mode_if #(
    parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH
);
    // Handshake rules: query_req is a level held until the one-cycle query_ack,
    // and slot_valid/info_* are only meaningful in the ack cycle. mem_rd_en,
    // tx_start and clear_rx_buffer are one-cycle strobes; mem_rd_data is valid
    // exactly one cycle after mem_rd_en; tx_busy rises the cycle after tx_start.
    logic [7:0]               rx_data;
    logic                     rx_done;
    logic                     clear_rx_buffer;
    logic [7:0]               tx_data;
    logic                     tx_start;
    logic                     tx_busy;
    logic                     query_req;
    logic [3:0]               query_slot;
    logic                     query_ack;
    logic                     slot_valid;
    logic [4:0]               info_m;
    logic [4:0]               info_n;
    logic [ADDR_WIDTH-1:0]    info_addr;
    logic                     mem_rd_en;
    logic [ADDR_WIDTH-1:0]    mem_rd_addr;
    logic [ELEMENT_WIDTH-1:0] mem_rd_data;

    modport master (
        input  rx_data, rx_done, tx_busy, query_ack, slot_valid,
               info_m, info_n, info_addr, mem_rd_data,
        output clear_rx_buffer, tx_data, tx_start, query_req, query_slot,
               mem_rd_en, mem_rd_addr
    );

    modport slave (
        output rx_data, rx_done, tx_busy, query_ack, slot_valid,
               info_m, info_n, info_addr, mem_rd_data,
        input  clear_rx_buffer, tx_data, tx_start, query_req, query_slot,
               mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/display_mode.sv
// Matrix display mode: takes a hex slot digit over UART, looks the slot up,
// then streams its elements as decimal text, space separated, one row per line.
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 8
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif
`ifndef ERR_NONE
`define ERR_NONE 4'h0
`endif
`ifndef ERR_DIM_RANGE
`define ERR_DIM_RANGE 4'h2
`endif

module display_mode #(
    parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode_active,
    input  logic                  timeout_reset,
    display_mode_if.master        bus,
    output logic [3:0]            sub_state,
    output logic [3:0]            error_code
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_WAIT_SLOT    = 4'd1,
        S_QUERY        = 4'd2,
        S_RD_ISSUE     = 4'd3,
        S_RD_WAIT      = 4'd4,
        S_CONVERT      = 4'd5,
        S_SEND_D2      = 4'd6,
        S_SEND_D1      = 4'd7,
        S_SEND_D0      = 4'd8,
        S_SEND_SPACE   = 4'd9,
        S_SEND_NEWLINE = 4'd10,
        S_DONE         = 4'd11
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            err_q, err_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  clr_q, clr_d;
    logic                  query_req_q, query_req_d;
    logic [3:0]            query_slot_q, query_slot_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic [4:0]            m_q, m_d;
    logic [4:0]            n_q, n_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [8:0]            elem_cnt_q, elem_cnt_d;
    logic [4:0]            col_q, col_d;
    logic [4:0]            row_q, row_d;
    logic [7:0]            elem_q, elem_d;
    logic [3:0]            hund_q, hund_d;
    logic [3:0]            tens_q, tens_d;
    logic [3:0]            ones_q, ones_d;

    logic [ELEMENT_WIDTH-1:0] rd_word;
    logic [4:0]            rx_hex;
    logic                  rx_is_sep;
    logic                  rx_new;
    logic                  tx_ok;
    logic [9:0]            total;
    logic                  last_elem;
    logic [3:0]            conv_h;
    logic [7:0]            conv_rem;
    logic [3:0]            conv_t;
    logic [3:0]            conv_o;

    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)      return {1'b1, 4'(c - 8'h30)};
        else if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
        else if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
        else                               return 5'd0;
    endfunction

    assign rd_word   = bus.mem_rd_data;
    assign rx_hex    = hex_decode(bus.rx_data);
    assign rx_is_sep = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A) ||
                       (bus.rx_data == 8'h20);
    // rx_done stays up until our clear pulse lands, so skip the cycle it is visible.
    assign rx_new    = bus.rx_done && !clr_q;
    // tx_busy only rises the cycle after tx_start, so the strobe itself also blocks.
    assign tx_ok     = !bus.tx_busy && !tx_start_q;
    assign total     = 10'(m_q) * 10'(n_q);
    assign last_elem = (10'(elem_cnt_q) == (total - 10'd1));

    assign conv_h   = (elem_q >= 8'd200) ? 4'd2 : (elem_q >= 8'd100) ? 4'd1 : 4'd0;
    assign conv_rem = (elem_q >= 8'd200) ? (elem_q - 8'd200) :
                      (elem_q >= 8'd100) ? (elem_q - 8'd100) : elem_q;
    assign conv_t   = 4'(conv_rem / 8'd10);
    assign conv_o   = 4'(conv_rem % 8'd10);

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        tx_data_d     = tx_data_q;
        query_req_d   = query_req_q;
        query_slot_d  = query_slot_q;
        mem_rd_addr_d = mem_rd_addr_q;
        m_d           = m_q;
        n_d           = n_q;
        base_d        = base_q;
        elem_cnt_d    = elem_cnt_q;
        col_d         = col_q;
        row_d         = row_q;
        elem_d        = elem_q;
        hund_d        = hund_q;
        tens_d        = tens_q;
        ones_d        = ones_q;
        tx_start_d    = 1'b0;
        clr_d         = 1'b0;
        mem_rd_en_d   = 1'b0;

        if (!mode_active) begin
            state_d     = S_IDLE;
            query_req_d = 1'b0;
        end else if (timeout_reset &&
                     (state_q == S_WAIT_SLOT || state_q == S_QUERY)) begin
            state_d     = S_IDLE;
            query_req_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    elem_cnt_d = 9'd0;
                    col_d      = 5'd0;
                    row_d      = 5'd0;
                    state_d    = S_WAIT_SLOT;
                end
                S_WAIT_SLOT: begin
                    if (rx_new) begin
                        clr_d = 1'b1;
                        if (rx_hex[4]) begin
                            query_slot_d = rx_hex[3:0];
                            err_d        = `ERR_NONE;
                            query_req_d  = 1'b1;
                            state_d      = S_QUERY;
                        end else if (!rx_is_sep) begin
                            err_d = `ERR_DIM_RANGE;
                            if (tx_ok) begin
                                tx_data_d  = 8'h21;
                                tx_start_d = 1'b1;
                            end
                        end
                    end
                end
                S_QUERY: begin
                    if (bus.query_ack) begin
                        query_req_d = 1'b0;
                        if (bus.slot_valid) begin
                            m_d        = bus.info_m;
                            n_d        = bus.info_n;
                            base_d     = bus.info_addr;
                            elem_cnt_d = 9'd0;
                            col_d      = 5'd0;
                            row_d      = 5'd0;
                            state_d    = S_RD_ISSUE;
                        end else begin
                            err_d   = `ERR_DIM_RANGE;
                            state_d = S_WAIT_SLOT;
                            if (tx_ok) begin
                                tx_data_d  = 8'h21;
                                tx_start_d = 1'b1;
                            end
                        end
                    end else begin
                        query_req_d = 1'b1;
                    end
                end
                S_RD_ISSUE: begin
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = base_q + ADDR_WIDTH'(elem_cnt_q);
                    state_d       = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // The strobe is registered, so data arrives once it has dropped again.
                    if (!mem_rd_en_q) begin
                        elem_d  = 8'(rd_word);
                        state_d = S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    hund_d = conv_h;
                    tens_d = conv_t;
                    ones_d = conv_o;
                    if (conv_h != 4'd0)      state_d = S_SEND_D2;
                    else if (conv_t != 4'd0) state_d = S_SEND_D1;
                    else                     state_d = S_SEND_D0;
                end
                S_SEND_D2: begin
                    if (tx_ok) begin
                        tx_data_d  = 8'h30 + {4'h0, hund_q};
                        tx_start_d = 1'b1;
                        state_d    = S_SEND_D1;
                    end
                end
                S_SEND_D1: begin
                    if (tx_ok) begin
                        tx_data_d  = 8'h30 + {4'h0, tens_q};
                        tx_start_d = 1'b1;
                        state_d    = S_SEND_D0;
                    end
                end
                S_SEND_D0: begin
                    if (tx_ok) begin
                        tx_data_d  = 8'h30 + {4'h0, ones_q};
                        tx_start_d = 1'b1;
                        state_d    = (col_q == (n_q - 5'd1)) ? S_SEND_NEWLINE : S_SEND_SPACE;
                    end
                end
                S_SEND_SPACE: begin
                    if (tx_ok) begin
                        tx_data_d  = 8'h20;
                        tx_start_d = 1'b1;
                        col_d      = col_q + 5'd1;
                        elem_cnt_d = elem_cnt_q + 9'd1;
                        state_d    = last_elem ? S_DONE : S_RD_ISSUE;
                    end
                end
                S_SEND_NEWLINE: begin
                    if (tx_ok) begin
                        tx_data_d  = 8'h0A;
                        tx_start_d = 1'b1;
                        col_d      = 5'd0;
                        row_d      = row_q + 5'd1;
                        elem_cnt_d = elem_cnt_q + 9'd1;
                        state_d    = last_elem ? S_DONE : S_RD_ISSUE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            err_q         <= `ERR_NONE;
            tx_data_q     <= 8'd0;
            tx_start_q    <= 1'b0;
            clr_q         <= 1'b0;
            query_req_q   <= 1'b0;
            query_slot_q  <= 4'd0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            m_q           <= 5'd0;
            n_q           <= 5'd0;
            base_q        <= '0;
            elem_cnt_q    <= 9'd0;
            col_q         <= 5'd0;
            row_q         <= 5'd0;
            elem_q        <= 8'd0;
            hund_q        <= 4'd0;
            tens_q        <= 4'd0;
            ones_q        <= 4'd0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            clr_q         <= clr_d;
            query_req_q   <= query_req_d;
            query_slot_q  <= query_slot_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            m_q           <= m_d;
            n_q           <= n_d;
            base_q        <= base_d;
            elem_cnt_q    <= elem_cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            elem_q        <= elem_d;
            hund_q        <= hund_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
        end
    end

    assign bus.clear_rx_buffer = clr_q;
    assign bus.tx_data         = tx_data_q;
    assign bus.tx_start        = tx_start_q;
    assign bus.query_req       = query_req_q;
    assign bus.query_slot      = query_slot_q;
    assign bus.mem_rd_en       = mem_rd_en_q;
    assign bus.mem_rd_addr     = mem_rd_addr_q;
    assign sub_state           = state_q;
    assign error_code          = err_q;

endmodule

// File: tb/tb_display_mode.sv
// Directed bench for display_mode: UART/slot-manager/memory models plus
// per-scenario tasks with hand-computed expected byte streams.
`ifndef ERR_NONE
`define ERR_NONE 4'h0
`endif
`ifndef ERR_DIM_RANGE
`define ERR_DIM_RANGE 4'h2
`endif
`timescale 1ns/1ps

module tb_display_mode;
    localparam int EW = 8;
    localparam int AW = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode_active = 1'b0;
    logic timeout_reset = 1'b0;
    logic [3:0] sub_state;
    logic [3:0] error_code;

    always #5 clk = ~clk;

    display_mode_if #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW)) bus ();

    display_mode #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode_active   (mode_active),
        .timeout_reset (timeout_reset),
        .bus           (bus),
        .sub_state     (sub_state),
        .error_code    (error_code)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- environment models ----------------
    logic [7:0]    rx_data_r = 8'd0;
    logic          rx_done_r = 1'b0;
    logic          q_ack = 1'b0;
    logic          q_valid = 1'b0;
    logic [4:0]    q_m = 5'd0;
    logic [4:0]    q_n = 5'd0;
    logic [AW-1:0] q_addr = '0;
    logic [EW-1:0] rd_data_r = '0;
    int            busy_cnt = 0;
    int            busy_len = 2;
    int            q_wait = 0;
    logic          q_enable = 1'b1;
    logic [3:0]    ack_slot = 4'd0;

    logic          slot_ok [16];
    logic [4:0]    slot_m [16];
    logic [4:0]    slot_n [16];
    logic [AW-1:0] slot_a [16];
    logic [7:0]    mem [0:(1<<AW)-1];

    assign bus.rx_data     = rx_data_r;
    assign bus.rx_done     = rx_done_r;
    assign bus.query_ack   = q_ack;
    assign bus.slot_valid  = q_valid;
    assign bus.info_m      = q_m;
    assign bus.info_n      = q_n;
    assign bus.info_addr   = q_addr;
    assign bus.mem_rd_data = rd_data_r;
    assign bus.tx_busy     = (busy_cnt != 0);

    // Slot manager: acks two cycles after seeing query_req.
    always @(posedge clk) begin
        if (bus.query_req && !q_ack && q_enable) begin
            if (q_wait == 2) begin
                q_ack    <= 1'b1;
                q_valid  <= slot_ok[bus.query_slot];
                q_m      <= slot_m[bus.query_slot];
                q_n      <= slot_n[bus.query_slot];
                q_addr   <= slot_a[bus.query_slot];
                ack_slot <= bus.query_slot;
                q_wait   <= 0;
            end else begin
                q_wait <= q_wait + 1;
            end
        end else begin
            q_ack  <= 1'b0;
            q_wait <= 0;
        end
    end

    // Logs: transmitted bytes, read addresses, strobe counts and pulse-width violations.
    logic [7:0]    tx_log[$];
    logic [AW-1:0] rd_log[$];
    int            clr_cnt = 0;
    int            qreq_cycles = 0;
    int            pulse_err = 0;
    logic          clr_logs = 1'b0;
    logic          prev_tx = 1'b0;
    logic          prev_rd = 1'b0;
    logic          prev_clr = 1'b0;

    always @(posedge clk) begin
        if (bus.mem_rd_en) rd_data_r <= mem[bus.mem_rd_addr];
        if (bus.tx_start) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        prev_tx  <= bus.tx_start;
        prev_rd  <= bus.mem_rd_en;
        prev_clr <= bus.clear_rx_buffer;
        if (clr_logs) begin
            tx_log.delete();
            rd_log.delete();
            clr_cnt     = 0;
            qreq_cycles = 0;
            pulse_err   = 0;
        end else begin
            if (bus.tx_start) tx_log.push_back(bus.tx_data);
            if (bus.mem_rd_en) rd_log.push_back(bus.mem_rd_addr);
            if (bus.clear_rx_buffer) clr_cnt++;
            if (bus.query_req) qreq_cycles++;
            if ((bus.tx_start && prev_tx) || (bus.mem_rd_en && prev_rd) ||
                (bus.clear_rx_buffer && prev_clr)) pulse_err++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        @(negedge clk);
        clr_logs = 1'b1;
        @(negedge clk);
        clr_logs = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        rx_data_r = b;
        rx_done_r = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.clear_rx_buffer) begin
                ok = 1'b1;
                break;
            end
        end
        rx_done_r = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sub_state == code) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0]    exp_q[$];
    logic [AW-1:0] exp_rd_q[$];

    task automatic load_exp_text(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        mode_active = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (sub_state !== 4'd0) begin n_fail++; $display("FAIL reset_sub_state: got %0d want 0", sub_state); end
        n_checks++; if (error_code !== `ERR_NONE) begin n_fail++; $display("FAIL reset_error_code: got %0h want %0h", error_code, `ERR_NONE); end
        n_checks++; if ({bus.tx_start, bus.clear_rx_buffer, bus.mem_rd_en, bus.query_req} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes: got %b want 0000", {bus.tx_start, bus.clear_rx_buffer, bus.mem_rd_en, bus.query_req}); end
        n_checks++; if (bus.tx_data !== 8'd0 || bus.mem_rd_addr !== '0 || bus.query_slot !== 4'd0) begin n_fail++; $display("FAIL reset_data: got tx=%0h addr=%0h slot=%0h want 0", bus.tx_data, bus.mem_rd_addr, bus.query_slot); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (sub_state !== 4'd1) begin n_fail++; $display("FAIL reset_to_wait_slot: got %0d want 1", sub_state); end
    endtask

    task automatic test_matrix_2x3(input string tag);
        bit ok, hit;
        int bad;
        clear_logs();
        send_rx(8'h33, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_rx_consumed: got no clear want clear", tag); end
        wait_state(4'd11, 600, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL %s_reach_done: got timeout want DONE", tag); end
        @(negedge clk);
        n_checks++; if (sub_state !== 4'd0) begin n_fail++; $display("FAIL %s_back_idle: got %0d want 0", tag, sub_state); end
        n_checks++; if (ack_slot !== 4'd3) begin n_fail++; $display("FAIL %s_query_slot: got %0d want 3", tag, ack_slot); end
        n_checks++; if (error_code !== `ERR_NONE) begin n_fail++; $display("FAIL %s_error_code: got %0h want %0h", tag, error_code, `ERR_NONE); end
        exp_rd_q.delete();
        for (int i = 0; i < 6; i++) exp_rd_q.push_back(AW'(10'h010 + i));
        bad = (rd_log.size() == exp_rd_q.size()) ? -1 : 0;
        for (int i = 0; i < rd_log.size() && i < exp_rd_q.size(); i++)
            if (rd_log[i] !== exp_rd_q[i] && bad < 0) bad = i;
        n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL %s_read_addrs: got %0d reads (first bad idx %0d) want 6 reads 0x10..0x15", tag, rd_log.size(), bad); end
        load_exp_text("1 2 3\n10 0 255\n");
        bad = (tx_log.size() == exp_q.size()) ? -1 : 0;
        for (int i = 0; i < tx_log.size() && i < exp_q.size(); i++)
            if (tx_log[i] !== exp_q[i] && bad < 0) bad = i;
        n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL %s_tx_stream: got %0d bytes (first bad idx %0d) want %0d bytes", tag, tx_log.size(), bad, exp_q.size()); end
        n_checks++; if (pulse_err !== 0) begin n_fail++; $display("FAIL %s_pulses: got %0d wide strobes want 0", tag, pulse_err); end
    endtask

    task automatic test_bad_char();
        bit ok;
        logic [7:0] first;
        clear_logs();
        send_rx(8'h78, ok);
        repeat (10) @(negedge clk);
        first = (tx_log.size() > 0) ? tx_log[0] : 8'hxx;
        n_checks++; if (tx_log.size() !== 1 || first !== 8'h21) begin n_fail++; $display("FAIL bad_char_bang: got %0d bytes first=%0h want 1 byte 21", tx_log.size(), first); end
        n_checks++; if (error_code !== `ERR_DIM_RANGE) begin n_fail++; $display("FAIL bad_char_error: got %0h want %0h", error_code, `ERR_DIM_RANGE); end
        n_checks++; if (sub_state !== 4'd1) begin n_fail++; $display("FAIL bad_char_state: got %0d want 1", sub_state); end
        n_checks++; if (qreq_cycles !== 0) begin n_fail++; $display("FAIL bad_char_no_query: got %0d req cycles want 0", qreq_cycles); end
    endtask

    task automatic test_invalid_slot();
        bit ok;
        logic [7:0] first;
        clear_logs();
        send_rx(8'h46, ok);
        repeat (15) @(negedge clk);
        first = (tx_log.size() > 0) ? tx_log[0] : 8'hxx;
        n_checks++; if (ack_slot !== 4'hF) begin n_fail++; $display("FAIL invalid_slot_query_slot: got %0d want 15", ack_slot); end
        n_checks++; if (tx_log.size() !== 1 || first !== 8'h21) begin n_fail++; $display("FAIL invalid_slot_bang: got %0d bytes first=%0h want 1 byte 21", tx_log.size(), first); end
        n_checks++; if (error_code !== `ERR_DIM_RANGE) begin n_fail++; $display("FAIL invalid_slot_error: got %0h want %0h", error_code, `ERR_DIM_RANGE); end
        n_checks++; if (sub_state !== 4'd1) begin n_fail++; $display("FAIL invalid_slot_state: got %0d want 1", sub_state); end
        n_checks++; if (rd_log.size() !== 0) begin n_fail++; $display("FAIL invalid_slot_no_read: got %0d reads want 0", rd_log.size()); end
    endtask

    task automatic test_separators();
        bit ok;
        clear_logs();
        send_rx(8'h0D, ok);
        send_rx(8'h0A, ok);
        send_rx(8'h20, ok);
        repeat (5) @(negedge clk);
        n_checks++; if (clr_cnt !== 3) begin n_fail++; $display("FAIL sep_clears: got %0d want 3", clr_cnt); end
        n_checks++; if (tx_log.size() !== 0) begin n_fail++; $display("FAIL sep_no_tx: got %0d bytes want 0", tx_log.size()); end
        n_checks++; if (sub_state !== 4'd1 || error_code !== `ERR_DIM_RANGE) begin n_fail++; $display("FAIL sep_hold: got state=%0d err=%0h want 1/%0h", sub_state, error_code, `ERR_DIM_RANGE); end
    endtask

    task automatic test_single_element();
        bit ok, hit;
        logic [15:0] got;
        clear_logs();
        send_rx(8'h61, ok);
        wait_state(4'd11, 200, hit);
        @(negedge clk);
        got = (tx_log.size() == 2) ? {tx_log[0], tx_log[1]} : 16'hxxxx;
        n_checks++; if (!hit || got !== 16'h300A) begin n_fail++; $display("FAIL one_by_one_zero: got %0d bytes %0h want 300a", tx_log.size(), got); end
        n_checks++; if (rd_log.size() !== 1 || rd_log[0] !== AW'(10'h3FF)) begin n_fail++; $display("FAIL one_by_one_addr: got %0d reads want 1 at 3ff", rd_log.size()); end
        n_checks++; if (ack_slot !== 4'hA || error_code !== `ERR_NONE) begin n_fail++; $display("FAIL one_by_one_slot: got slot=%0h err=%0h want a/%0h", ack_slot, error_code, `ERR_NONE); end
    endtask

    task automatic test_timeout();
        bit ok;
        q_enable = 1'b0;
        send_rx(8'h35, ok);
        repeat (4) @(negedge clk);
        n_checks++; if (sub_state !== 4'd2 || bus.query_req !== 1'b1) begin n_fail++; $display("FAIL timeout_pending: got state=%0d req=%b want 2/1", sub_state, bus.query_req); end
        timeout_reset = 1'b1;
        @(negedge clk);
        timeout_reset = 1'b0;
        n_checks++; if (sub_state !== 4'd0 || bus.query_req !== 1'b0) begin n_fail++; $display("FAIL timeout_abort: got state=%0d req=%b want 0/0", sub_state, bus.query_req); end
        q_enable = 1'b1;
        @(negedge clk);
        n_checks++; if (sub_state !== 4'd1) begin n_fail++; $display("FAIL timeout_restart: got %0d want 1", sub_state); end
    endtask

    task automatic test_big_busy();
        bit ok, hit;
        int bad;
        logic [7:0] last;
        busy_len = 20;
        clear_logs();
        exp_q.delete();
        exp_rd_q.delete();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                string s;
                int k = r * 16 + c;
                exp_rd_q.push_back(AW'(10'h100 + k));
                s = $sformatf("%0d", mem[10'h100 + k]);
                for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
                exp_q.push_back((c == 15) ? 8'h0A : 8'h20);
            end
        end
        send_rx(8'h37, ok);
        repeat (500) @(negedge clk);
        timeout_reset = 1'b1;
        @(negedge clk);
        timeout_reset = 1'b0;
        wait_state(4'd11, 40000, hit);
        @(negedge clk);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL big_done: got timeout want DONE"); end
        bad = (rd_log.size() == 256) ? -1 : 0;
        for (int i = 0; i < rd_log.size() && i < 256; i++)
            if (rd_log[i] !== exp_rd_q[i] && bad < 0) bad = i;
        n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL big_reads: got %0d reads (first bad idx %0d) want 256", rd_log.size(), bad); end
        bad = (tx_log.size() == exp_q.size()) ? -1 : 0;
        for (int i = 0; i < tx_log.size() && i < exp_q.size(); i++)
            if (tx_log[i] !== exp_q[i] && bad < 0) bad = i;
        n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL big_tx_stream: got %0d bytes (first bad idx %0d) want %0d", tx_log.size(), bad, exp_q.size()); end
        last = (tx_log.size() > 0) ? tx_log[tx_log.size() - 1] : 8'hxx;
        n_checks++; if (last !== 8'h0A) begin n_fail++; $display("FAIL big_last_byte: got %0h want 0a", last); end
        n_checks++; if (pulse_err !== 0) begin n_fail++; $display("FAIL big_pulses: got %0d wide strobes want 0", pulse_err); end
        busy_len = 2;
    endtask

    task automatic test_abort();
        bit ok, hit;
        int n_tx;
        clear_logs();
        send_rx(8'h33, ok);
        wait_state(4'd7, 600, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL abort_reach_d1: got timeout want SEND_D1"); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (sub_state !== 4'd0 || error_code !== `ERR_NONE) begin n_fail++; $display("FAIL abort_rst_state: got %0d/%0h want 0/%0h", sub_state, error_code, `ERR_NONE); end
        n_checks++; if ({bus.tx_start, bus.clear_rx_buffer, bus.mem_rd_en, bus.query_req} !== 4'b0000 || bus.tx_data !== 8'd0 || bus.mem_rd_addr !== '0 || bus.query_slot !== 4'd0) begin n_fail++; $display("FAIL abort_rst_outputs: got strobes=%b tx=%0h addr=%0h slot=%0h want all 0", {bus.tx_start, bus.clear_rx_buffer, bus.mem_rd_en, bus.query_req}, bus.tx_data, bus.mem_rd_addr, bus.query_slot); end
        n_tx = tx_log.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++; if (tx_log.size() !== n_tx || sub_state !== 4'd1) begin n_fail++; $display("FAIL abort_rst_quiet: got %0d extra bytes state=%0d want 0/1", tx_log.size() - n_tx, sub_state); end

        clear_logs();
        send_rx(8'h33, ok);
        wait_state(4'd4, 100, hit);
        mode_active = 1'b0;
        @(negedge clk);
        n_checks++; if (!hit || sub_state !== 4'd0) begin n_fail++; $display("FAIL abort_mode_state: got hit=%0b state=%0d want 1/0", hit, sub_state); end
        n_checks++; if ({bus.tx_start, bus.clear_rx_buffer, bus.mem_rd_en, bus.query_req} !== 4'b0000) begin n_fail++; $display("FAIL abort_mode_strobes: got %b want 0000", {bus.tx_start, bus.clear_rx_buffer, bus.mem_rd_en, bus.query_req}); end
        n_tx = tx_log.size();
        repeat (20) @(negedge clk);
        n_checks++; if (tx_log.size() !== n_tx || sub_state !== 4'd0) begin n_fail++; $display("FAIL abort_mode_quiet: got %0d extra bytes state=%0d want 0/0", tx_log.size() - n_tx, sub_state); end
        mode_active = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < 16; i++) begin
            slot_ok[i] = 1'b0;
            slot_m[i]  = 5'd1;
            slot_n[i]  = 5'd1;
            slot_a[i]  = '0;
        end
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'd0;
        slot_ok[3] = 1'b1; slot_m[3] = 5'd2;  slot_n[3] = 5'd3;  slot_a[3] = AW'(10'h010);
        slot_ok[7] = 1'b1; slot_m[7] = 5'd16; slot_n[7] = 5'd16; slot_a[7] = AW'(10'h100);
        slot_ok[10] = 1'b1; slot_a[10] = AW'(10'h3FF);
        mem[10'h010] = 8'd1;  mem[10'h011] = 8'd2; mem[10'h012] = 8'd3;
        mem[10'h013] = 8'd10; mem[10'h014] = 8'd0; mem[10'h015] = 8'd255;
        mem[10'h3FF] = 8'd0;
        for (int k = 0; k < 256; k++) mem[10'h100 + k] = 8'((k * 37 + 5) % 256);

        test_reset();
        test_matrix_2x3("matrix");
        test_bad_char();
        test_invalid_slot();
        test_separators();
        test_single_element();
        test_timeout();
        test_big_busy();
        test_abort();
        test_matrix_2x3("fresh");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got no completion want finish before 3ms");
        $fatal(1, "watchdog expired");
    end

endmodule
